mux_rr_nxw: RTL and testbench
=============================

MUX_RR_NXW -- requirements
Module: mux_rr_nxw

Interface
REQ-001 The module SHALL have parameter N_CH, default 8, giving the number of input channels (legal values 2..64).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the width of each channel word (legal values ≥1).
REQ-003 The module SHALL have parameter RR_MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 The module SHALL derive localparam SEL_W = max(1, clog2(N_CH)).
REQ-005 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 The module SHALL have port in_data  input  N_CH*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 The module SHALL have port in_valid  input  N_CH  per-channel valid.
REQ-009 The module SHALL have port in_ready  output  N_CH  per-channel ready.
REQ-010 The module SHALL have port sel  input  SEL_W  channel select, used only when RR_MODE=0.
REQ-011 The module SHALL have port out_data  output  DATA_W  registered selected word.
REQ-012 The module SHALL have port out_ch  output  SEL_W  index of the channel that supplied out_data.
REQ-013 The module SHALL have port out_valid  output  1  out_data/out_ch hold a word.
REQ-014 The module SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-015 Transfers SHALL follow valid/ready semantics: an input transfer occurs on channel k when in_valid[k] && in_ready[k] at a rising edge; an output transfer occurs when out_valid && out_ready.
REQ-016 The output register SHALL be loadable (load_en=1) when out_valid=0 or an output transfer occurs in the same cycle.
REQ-017 At most one in_ready bit SHALL be 1 in any cycle; in_ready SHALL be combinational from load_en, the grant and in_valid, with no dependency on in_data.
REQ-018 With RR_MODE=0, the grant SHALL be channel sel, and in_ready[sel] = load_en; if sel ≥ N_CH, all in_ready SHALL be 0 and no load occurs.
REQ-019 With RR_MODE=1, the grant SHALL be the first channel with in_valid=1, searching upward from pointer ptr with wrap from N_CH-1 to 0; in_ready[grant] = load_en; with no valid channel, all in_ready SHALL be 0.
REQ-020 With RR_MODE=1, after an input transfer from channel g, ptr SHALL become (g+1) mod N_CH; without an input transfer, ptr SHALL hold.
REQ-021 On an input transfer, out_data SHALL take that channel's word, out_ch SHALL take the channel index, and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-022 On an output transfer with no simultaneous input transfer, out_valid SHALL go to 0 next cycle; out_data and out_ch SHALL hold their values.
REQ-023 A simultaneous output and input transfer SHALL replace the word with out_valid staying 1, sustaining 1 word/cycle throughput.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL remain stable, and all in_ready SHALL be 0.
REQ-025 The output state SHALL be exactly two states: EMPTY (out_valid=0) and FULL (out_valid=1), with transitions only as in REQ-021..REQ-024.

Reset
REQ-026 While rst_n=0, the module SHALL force out_valid=0, out_data=0, out_ch=0, ptr=0 and all in_ready=0, independent of clk.
REQ-027 Assertion of rst_n mid-operation SHALL discard any held word; no transfer SHALL complete on the edge at which rst_n is low.
REQ-028 After rst_n deasserts, the first rising edge SHALL be able to accept an input transfer.

Verification (N_CH=8, DATA_W=8)
REQ-029 A bench SHALL cover: RR_MODE=0, sel=5, in_valid=8'h20, ch5=8'hA5, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=8'hA5, out_ch=5.
REQ-030 A bench SHALL cover: RR_MODE=0, sel=3, in_valid=8'h00 -> in_ready=8'h08, but out_valid stays 0.
REQ-031 A bench SHALL cover: RR_MODE=1, in_valid=8'hFF held, out_ready=1, ptr=0 after reset -> out_ch sequence 0,1,...,7,0 on consecutive cycles with no gaps.
REQ-032 A bench SHALL cover: RR_MODE=1, in_valid=8'h81, ptr=0 -> grants 0, then 7, then 0 (wrap); ptr after the grant to 7 equals 0.
REQ-033 A bench SHALL cover: out_valid=1 with out_ready=0 for 4 cycles -> out_data/out_ch stable and in_ready=0; on out_ready=1 with in_valid pending, the new word appears next cycle.
REQ-034 A bench SHALL cover: rst_n pulsed low between edges while out_valid=1 -> out_valid=0, out_data=0 and in_ready=0 immediately; ptr restarts at 0.

Source files
------------

// File: rtl/mux_rr_nxw.sv
// N-channel to 1 registered multiplexer with valid/ready handshakes.
// The channel is chosen either by an external select or by a round-robin
// arbiter. A single output register sustains one word per cycle.
module mux_rr_nxw #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 0,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [SEL_W-1:0]    ch_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [SEL_W-1:0]    grant;
  logic                grant_ok;
  logic                load_en;
  logic                in_xfer;
  logic [DATA_W-1:0]   grant_data;

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  // The register can take a new word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant: external select, or first valid channel searching upward from ptr.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_ok = 1'b0;
    if (RR_MODE == 0) begin
      grant    = sel;
      grant_ok = (int'(sel) < N_CH);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!grant_ok && in_valid[idx]) begin
          grant    = idx[SEL_W-1:0];
          grant_ok = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted channel; held low throughout reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && grant_ok && load_en) in_ready[grant] = 1'b1;
  end

  assign in_xfer = |(in_valid & in_ready);

  // Word of the granted channel.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == k[SEL_W-1:0]) grant_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  // Output occupancy next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (in_xfer) state_d = StFull;
      StFull:  if (out_ready && !in_xfer) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Output word and source index; hold when nothing is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
    end else if (in_xfer) begin
      data_q <= grant_data;
      ch_q   <= grant;
    end
  end

  // Round-robin pointer moves just past the channel that transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (RR_MODE != 0 && in_xfer) begin
      if (int'(grant) == N_CH - 1) ptr_q <= '0;
      else                         ptr_q <= grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_nxw.sv
// Directed bench for mux_rr_nxw: one instance per selection mode.
module tb_mux_rr_nxw;

  localparam int N_CH   = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  logic clk;
  logic rst_n;

  logic [N_CH*DATA_W-1:0] s_in_data, r_in_data;
  logic [N_CH-1:0]        s_in_valid, r_in_valid, s_in_ready, r_in_ready;
  logic [SEL_W-1:0]       s_sel, r_sel, s_out_ch, r_out_ch;
  logic [DATA_W-1:0]      s_out_data, r_out_data;
  logic                   s_out_valid, r_out_valid, s_out_ready, r_out_ready;

  int total;
  int bad;

  mux_rr_nxw #(.N_CH(N_CH), .DATA_W(DATA_W), .RR_MODE(0)) u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .sel       (s_sel),
    .out_data  (s_out_data),
    .out_ch    (s_out_ch),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready)
  );

  mux_rr_nxw #(.N_CH(N_CH), .DATA_W(DATA_W), .RR_MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (r_in_data),
    .in_valid  (r_in_valid),
    .in_ready  (r_in_ready),
    .sel       (r_sel),
    .out_data  (r_out_data),
    .out_ch    (r_out_ch),
    .out_valid (r_out_valid),
    .out_ready (r_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n       = 1'b0;
    s_sel       = 3'd0;
    s_in_valid  = 8'hFF;
    s_out_ready = 1'b1;
    r_in_valid  = 8'h00;
    r_out_ready = 1'b1;
    #1;
    total++;
    if (s_out_valid !== 1'b0 || s_out_data !== 8'h00 || s_out_ch !== 3'd0) begin
      bad++;
      $display("FAIL reset_sel_out: valid=%b data=%h ch=%0d want 0/00/0",
               s_out_valid, s_out_data, s_out_ch);
    end
    total++;
    if (s_in_ready !== 8'h00) begin
      bad++;
      $display("FAIL reset_sel_ready: got %h want 00", s_in_ready);
    end
    total++;
    if (r_out_valid !== 1'b0 || r_out_data !== 8'h00 || r_out_ch !== 3'd0) begin
      bad++;
      $display("FAIL reset_rr_out: valid=%b data=%h ch=%0d want 0/00/0",
               r_out_valid, r_out_data, r_out_ch);
    end
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge_no_load: valid=%b want 0", s_out_valid);
    end
    s_in_valid = 8'h00;
    rst_n      = 1'b1;
  endtask

  task automatic test_sel_basic();
    s_in_data[5*8 +: 8] = 8'hA5;
    s_sel       = 3'd5;
    s_in_valid  = 8'h20;
    s_out_ready = 1'b1;
    #1;
    total++;
    if (s_in_ready !== 8'h20) begin
      bad++;
      $display("FAIL sel_ready: got %h want 20", s_in_ready);
    end
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 8'hA5 || s_out_ch !== 3'd5) begin
      bad++;
      $display("FAIL sel_load: valid=%b data=%h ch=%0d want 1/a5/5",
               s_out_valid, s_out_data, s_out_ch);
    end
    s_in_valid = 8'h00;
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b0 || s_out_data !== 8'hA5 || s_out_ch !== 3'd5) begin
      bad++;
      $display("FAIL sel_drain: valid=%b data=%h ch=%0d want 0/a5/5",
               s_out_valid, s_out_data, s_out_ch);
    end
  endtask

  task automatic test_sel_no_valid();
    s_sel      = 3'd3;
    s_in_valid = 8'h00;
    #1;
    total++;
    if (s_in_ready !== 8'h08) begin
      bad++;
      $display("FAIL novalid_ready: got %h want 08", s_in_ready);
    end
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL novalid_out: valid=%b want 0", s_out_valid);
    end
  endtask

  task automatic test_backpressure();
    s_in_data[2*8 +: 8] = 8'h42;
    s_sel       = 3'd2;
    s_in_valid  = 8'h04;
    s_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 8'h42 || s_out_ch !== 3'd2) begin
      bad++;
      $display("FAIL bp_load: valid=%b data=%h ch=%0d want 1/42/2",
               s_out_valid, s_out_data, s_out_ch);
    end
    s_out_ready = 1'b0;
    s_in_data[2*8 +: 8] = 8'h5C;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (s_in_ready !== 8'h00) begin
        bad++;
        $display("FAIL bp_ready[%0d]: got %h want 00", i, s_in_ready);
      end
      @(negedge clk);
      total++;
      if (s_out_valid !== 1'b1 || s_out_data !== 8'h42 || s_out_ch !== 3'd2) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d want 1/42/2",
                 i, s_out_valid, s_out_data, s_out_ch);
      end
    end
    s_in_data[6*8 +: 8] = 8'hC6;
    s_sel       = 3'd6;
    s_in_valid  = 8'h40;
    s_out_ready = 1'b1;
    #1;
    total++;
    if (s_in_ready !== 8'h40) begin
      bad++;
      $display("FAIL bp_release_ready: got %h want 40", s_in_ready);
    end
    @(negedge clk);
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 8'hC6 || s_out_ch !== 3'd6) begin
      bad++;
      $display("FAIL bp_replace: valid=%b data=%h ch=%0d want 1/c6/6",
               s_out_valid, s_out_data, s_out_ch);
    end
    s_in_valid = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_rr_all();
    logic [7:0] want;
    for (int k = 0; k < N_CH; k++) r_in_data[k*8 +: 8] = 8'h30 + 8'(k);
    r_in_valid  = 8'hFF;
    r_out_ready = 1'b1;
    #1;
    total++;
    if (r_in_ready !== 8'h01) begin
      bad++;
      $display("FAIL rr_first_ready: got %h want 01", r_in_ready);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      want = 8'h30 + 8'(i % 8);
      total++;
      if (r_out_valid !== 1'b1 || r_out_ch !== 3'(i % 8) || r_out_data !== want) begin
        bad++;
        $display("FAIL rr_seq[%0d]: valid=%b ch=%0d data=%h want 1/%0d/%h",
                 i, r_out_valid, r_out_ch, r_out_data, i % 8, want);
      end
    end
    // Leave a word held so the next reset has something to discard.
    r_in_valid  = 8'h00;
    r_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n       = 1'b0;
    r_in_valid  = 8'hFF;
    r_out_ready = 1'b1;
    s_sel       = 3'd1;
    s_in_valid  = 8'h02;
    #1;
    total++;
    if (r_out_valid !== 1'b0 || r_out_data !== 8'h00 || r_out_ch !== 3'd0) begin
      bad++;
      $display("FAIL midreset_out: valid=%b data=%h ch=%0d want 0/00/0",
               r_out_valid, r_out_data, r_out_ch);
    end
    total++;
    if (r_in_ready !== 8'h00 || s_in_ready !== 8'h00) begin
      bad++;
      $display("FAIL midreset_ready: rr=%h sel=%h want 00/00", r_in_ready, s_in_ready);
    end
    @(negedge clk);
    total++;
    if (r_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_edge: rr=%b sel=%b want 0/0", r_out_valid, s_out_valid);
    end
    r_in_valid = 8'h00;
    s_in_valid = 8'h00;
    rst_n      = 1'b1;
  endtask

  task automatic test_rr_wrap();
    r_in_data[0 +: 8]   = 8'h11;
    r_in_data[7*8 +: 8] = 8'h77;
    r_in_valid  = 8'h81;
    r_out_ready = 1'b1;
    #1;
    total++;
    if (r_in_ready !== 8'h01) begin
      bad++;
      $display("FAIL wrap_ready0: got %h want 01", r_in_ready);
    end
    @(negedge clk);
    total++;
    if (r_out_ch !== 3'd0 || r_out_data !== 8'h11 || r_in_ready !== 8'h80) begin
      bad++;
      $display("FAIL wrap_g0: ch=%0d data=%h ready=%h want 0/11/80",
               r_out_ch, r_out_data, r_in_ready);
    end
    @(negedge clk);
    total++;
    if (r_out_ch !== 3'd7 || r_out_data !== 8'h77 || r_in_ready !== 8'h01) begin
      bad++;
      $display("FAIL wrap_g7: ch=%0d data=%h ready=%h want 7/77/01",
               r_out_ch, r_out_data, r_in_ready);
    end
    @(negedge clk);
    total++;
    if (r_out_valid !== 1'b1 || r_out_ch !== 3'd0 || r_out_data !== 8'h11) begin
      bad++;
      $display("FAIL wrap_g0b: valid=%b ch=%0d data=%h want 1/0/11",
               r_out_valid, r_out_ch, r_out_data);
    end
    r_in_valid = 8'h00;
    @(negedge clk);
    total++;
    if (r_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_drain: valid=%b want 0", r_out_valid);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    s_in_data = '0;
    r_in_data = '0;
    r_sel     = 3'd0;
    test_reset();
    test_sel_basic();
    test_sel_no_valid();
    test_backpressure();
    test_rr_all();
    test_reset_mid();
    test_rr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
